key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_cond_pkg.sv | 28 ++
 rtl/key_conditioner_debounce.sv | 61 ++++++
 rtl/key_conditioner.sv | 135 +++++++++++++
 tb/tb_key_conditioner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// Shared types and default timing for the key conditioner.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package key_cond_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  // 20 ms, 500 ms and 100 ms at 50 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Lowest set bit wins: KEY0 has the highest priority.
  function automatic dir_t lowest_dir(input logic [3:0] v);
    dir_t d;
    if (v[0])      d = DIR_RIGHT;
    else if (v[1]) d = DIR_UP;
    else if (v[2]) d = DIR_LEFT;
    else           d = DIR_DOWN;
    return d;
  endfunction

endpackage

// File: rtl/key_conditioner_debounce.sv
// One-input debouncer: 2-flop synchronizer, stability counter, stable register.
// Latency: 2 + N cycles from a clean raw edge to level_o.
// Backpressure: none; free-running.
module debounce_cell
  import key_cond_pkg::*;
#(
  parameter int N      = DEF_DEBOUNCE_CYCLES,
  parameter bit INVERT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

  logic [1:0]    sync_q;
  logic [1:0]    fill_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          sync_val;

  // Polarity is corrected only after the synchronizer.
  assign sync_val = sync_q[1] ^ INVERT;
  assign level_o  = stable_q;

  // Count consecutive disagreeing cycles; accept the new value at CNT_MAX.
  // fill_q keeps the counter idle until the synchronizer holds real pin
  // samples, so the cleared reset value of the flops (which reads as
  // "pressed" after inversion) is never counted.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (!fill_q[1] || (sync_val == stable_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync_val;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer, fill tracker, counter and stable value registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], raw_i};
      fill_q   <= {fill_q[0], 1'b1};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Debounces KEY[3:0]/SW0, emits press pulses and a valid/ready direction command.
// Latency: level 2+DEBOUNCE_CYCLES cycles, press pulse +1, dir_valid_o +1 more.
// Backpressure: single-entry; a new press overwrites a pending dir_o (latest wins).
// Optional auto-repeat is built when KEY_COND_AUTOREPEAT_EN is defined.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [3:0] key_n_i,
  input  logic       sw_i,
  output logic [3:0] key_level_o,
  output logic       sw_level_o,
  output logic [3:0] key_press_o,
  output logic       dir_valid_o,
  output logic [1:0] dir_o,
  input  logic       dir_ready_i
);

  logic [3:0] level_w;
  logic       sw_w;
  logic [3:0] level_dly_q;
  logic [3:0] rise_w;
  logic [3:0] rpt_vec;
  logic [3:0] press_q, press_d;
  dir_t       dir_q, dir_d;
  logic       valid_q, valid_d;

  for (genvar g = 0; g < 4; g++) begin : g_key
    debounce_cell #(.N(DEBOUNCE_CYCLES), .INVERT(1'b1)) u_key (
      .clk_i   (clk_clk),
      .rst_ni  (reset_reset_n),
      .raw_i   (key_n_i[g]),
      .level_o (level_w[g])
    );
  end

  debounce_cell #(.N(DEBOUNCE_CYCLES), .INVERT(1'b0)) u_sw (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .raw_i   (sw_i),
    .level_o (sw_w)
  );

  assign rise_w = level_w & ~level_dly_q;

`ifdef KEY_COND_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [RW-1:0] rpt_lim;
  logic          rpt_first_q, rpt_first_d;
  logic          rpt_src_q;
  logic          rpt_fire;
  logic          held_any;
  logic [1:0]    hidx;

  // Time since the last pulse of the lowest-index held key; the first gap
  // uses REPEAT_DELAY, later ones REPEAT_PERIOD. rpt_src_q tells whether
  // the pulse now on key_press_o came from the repeat path.
  always_comb begin
    held_any    = |level_w;
    hidx        = lowest_dir(level_w);
    rpt_lim     = rpt_first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
    rpt_fire    = held_any && !press_q[hidx] && (rpt_cnt_q == rpt_lim);
    rpt_vec     = rpt_fire ? (4'b0001 << hidx) : 4'b0000;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    if (!held_any) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (press_q[hidx]) begin
      rpt_cnt_d   = RW'(1);
      rpt_first_d = ~rpt_src_q;
    end else if (rpt_cnt_q != '1) begin
      rpt_cnt_d = rpt_cnt_q + 1'b1;
    end
  end

  // Repeat counter state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
      rpt_src_q   <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
      rpt_src_q   <= rpt_fire;
    end
  end
`else
  assign rpt_vec = 4'b0000;
`endif

  // Press pulses and the single-entry direction command register.
  always_comb begin
    press_d = rise_w | rpt_vec;
    dir_d   = dir_q;
    valid_d = valid_q;
    if (|press_q) begin
      dir_d   = lowest_dir(press_q);
      valid_d = 1'b1;
    end else if (valid_q && dir_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output-side registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      level_dly_q <= '0;
      press_q     <= '0;
      dir_q       <= DIR_RIGHT;
      valid_q     <= 1'b0;
    end else begin
      level_dly_q <= level_w;
      press_q     <= press_d;
      dir_q       <= dir_d;
      valid_q     <= valid_d;
    end
  end

  assign key_level_o = level_w;
  assign sw_level_o  = sw_w;
  assign key_press_o = press_q;
  assign dir_valid_o = valid_q;
  assign dir_o       = dir_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// Expected repeat pulse train depends on KEY_COND_AUTOREPEAT_EN.
module tb_key_conditioner;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [3:0] key_n_i;
  logic       sw_i;
  logic [3:0] key_level_o;
  logic       sw_level_o;
  logic [3:0] key_press_o;
  logic       dir_valid_o;
  logic [1:0] dir_o;
  logic       dir_ready_i;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0;
  int pc[4] = '{0, 0, 0, 0};
  bit rec_en = 1'b0;
  int rec_t[$];

`ifdef KEY_COND_AUTOREPEAT_EN
  localparam int EXP_N = 5;
`else
  localparam int EXP_N = 1;
`endif
  int exp_off[5] = '{0, 20, 26, 32, 38};

  key_conditioner #(
    .DEBOUNCE_CYCLES (8),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (6)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .key_n_i       (key_n_i),
    .sw_i          (sw_i),
    .key_level_o   (key_level_o),
    .sw_level_o    (sw_level_o),
    .key_press_o   (key_press_o),
    .dir_valid_o   (dir_valid_o),
    .dir_o         (dir_o),
    .dir_ready_i   (dir_ready_i)
  );

  always #5 clk_clk = ~clk_clk;

  always @(posedge clk_clk) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk_clk) begin
    for (int i = 0; i < 4; i++) if (key_press_o[i]) pc[i] = pc[i] + 1;
    if (rec_en && key_press_o[0]) rec_t.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int p0;
    int c0;

    // Reset
    reset_reset_n = 1'b0;
    key_n_i       = 4'hF;
    sw_i          = 1'b0;
    dir_ready_i   = 1'b0;
    #1;
    chk("rst_level", {28'd0, key_level_o}, 32'd0);
    chk("rst_valid", {31'd0, dir_valid_o}, 32'd0);
    tick(3);
    chk("rst_press", {28'd0, key_press_o}, 32'd0);
    chk("rst_dir",   {30'd0, dir_o}, 32'd0);
    chk("rst_sw",    {31'd0, sw_level_o}, 32'd0);
    reset_reset_n = 1'b1;
    tick(12);
    chk("idle_level", {28'd0, key_level_o}, 32'd0);
    chk("idle_pulses", pc[0] + pc[1] + pc[2] + pc[3], 32'd0);

    // Clean press of KEY1
    key_n_i = 4'b1101;
    tick(9);
    chk("clean_lvl_c9", {28'd0, key_level_o}, 32'h0);
    tick(1);
    chk("clean_lvl_c10", {28'd0, key_level_o}, 32'h2);
    chk("clean_press_c10", {28'd0, key_press_o}, 32'h0);
    tick(1);
    chk("clean_press_c11", {28'd0, key_press_o}, 32'h2);
    chk("clean_valid_c11", {31'd0, dir_valid_o}, 32'd0);
    tick(1);
    chk("clean_press_c12", {28'd0, key_press_o}, 32'h0);
    chk("clean_valid_c12", {31'd0, dir_valid_o}, 32'd1);
    chk("clean_dir_c12", {30'd0, dir_o}, 32'd1);
    tick(3);
    chk("clean_dir_hold", {30'd0, dir_o}, 32'd1);
    dir_ready_i = 1'b1;
    tick(1);
    dir_ready_i = 1'b0;
    chk("clean_handshake", {31'd0, dir_valid_o}, 32'd0);
    p0 = pc[1];
    key_n_i = 4'hF;
    tick(12);
    chk("release_no_pulse", pc[1] - p0, 32'd0);
    chk("release_level", {28'd0, key_level_o}, 32'h0);

    // Switch level
    sw_i = 1'b1;
    tick(9);
    chk("sw_c9", {31'd0, sw_level_o}, 32'd0);
    tick(1);
    chk("sw_c10", {31'd0, sw_level_o}, 32'd1);
    sw_i = 1'b0;
    tick(12);
    chk("sw_off", {31'd0, sw_level_o}, 32'd0);

    // Bouncing KEY0
    p0 = pc[0];
    for (int k = 0; k < 10; k++) begin
      key_n_i[0] = ~key_n_i[0];
      tick(3);
    end
    chk("bounce_no_pulse", pc[0] - p0, 32'd0);
    key_n_i[0] = 1'b0;
    tick(9);
    chk("bounce_lvl_c9", {28'd0, key_level_o}, 32'h0);
    tick(1);
    chk("bounce_lvl_c10", {28'd0, key_level_o}, 32'h1);
    tick(1);
    chk("bounce_press_c11", {28'd0, key_press_o}, 32'h1);
    tick(5);
    chk("bounce_one_pulse", pc[0] - p0, 32'd1);
    chk("bounce_dir", {30'd0, dir_o}, 32'd0);
    dir_ready_i = 1'b1;
    tick(1);
    dir_ready_i = 1'b0;
    key_n_i = 4'hF;
    tick(12);

    // Backpressure: KEY2 then KEY3 overwrite
    key_n_i = 4'b1011;
    tick(12);
    chk("bp_dir_key2", {30'd0, dir_o}, 32'd2);
    chk("bp_valid_key2", {31'd0, dir_valid_o}, 32'd1);
    key_n_i = 4'b0011;
    tick(12);
    chk("bp_dir_key3", {30'd0, dir_o}, 32'd3);
    tick(3);
    chk("bp_valid_held", {31'd0, dir_valid_o}, 32'd1);
    chk("bp_dir_held", {30'd0, dir_o}, 32'd3);
    dir_ready_i = 1'b1;
    tick(1);
    dir_ready_i = 1'b0;
    chk("bp_accept", {31'd0, dir_valid_o}, 32'd0);
    key_n_i = 4'hF;
    tick(12);

    // Simultaneous KEY1 + KEY3, then press coincident with handshake
    key_n_i = 4'b0101;
    tick(11);
    chk("sim_press", {28'd0, key_press_o}, 32'hA);
    tick(1);
    chk("sim_dir", {30'd0, dir_o}, 32'd1);
    chk("sim_valid", {31'd0, dir_valid_o}, 32'd1);
    key_n_i = 4'b0100;
    tick(11);
    chk("coinc_press", {28'd0, key_press_o}, 32'h1);
    dir_ready_i = 1'b1;
    tick(1);
    dir_ready_i = 1'b0;
    chk("coinc_valid", {31'd0, dir_valid_o}, 32'd1);
    chk("coinc_dir", {30'd0, dir_o}, 32'd0);
    dir_ready_i = 1'b1;
    tick(1);
    dir_ready_i = 1'b0;
    chk("coinc_accept", {31'd0, dir_valid_o}, 32'd0);
    key_n_i = 4'hF;
    tick(12);

    // Reset mid-debounce with a command pending
    key_n_i = 4'b1101;
    tick(12);
    chk("rstm_pre_valid", {31'd0, dir_valid_o}, 32'd1);
    key_n_i = 4'b1001;
    tick(5);
    reset_reset_n = 1'b0;
    #1;
    chk("rstm_level", {28'd0, key_level_o}, 32'h0);
    chk("rstm_valid", {31'd0, dir_valid_o}, 32'd0);
    chk("rstm_dir",   {30'd0, dir_o}, 32'd0);
    chk("rstm_press", {28'd0, key_press_o}, 32'h0);
    tick(3);
    reset_reset_n = 1'b1;
    p0 = pc[2];
    tick(9);
    chk("rstm_lvl_c9", {28'd0, key_level_o}, 32'h0);
    chk("rstm_no_early", pc[2] - p0, 32'd0);
    tick(1);
    chk("rstm_lvl_c10", {28'd0, key_level_o}, 32'h6);
    tick(1);
    chk("rstm_press_c11", {28'd0, key_press_o}, 32'h6);
    tick(1);
    chk("rstm_dir_c12", {30'd0, dir_o}, 32'd1);
    dir_ready_i = 1'b1;
    key_n_i = 4'hF;
    tick(12);

    // Held KEY0: auto-repeat train (or single pulse)
    rec_en = 1'b1;
    c0 = cyc;
    key_n_i = 4'b1110;
    tick(40);
    key_n_i = 4'hF;
    tick(40);
    rec_en = 1'b0;
    chk("rpt_count", rec_t.size(), EXP_N);
    if (rec_t.size() > 0) chk("rpt_first_at", rec_t[0] - c0, 32'd11);
    for (int i = 1; i < EXP_N; i++) begin
      if (i < rec_t.size()) chk($sformatf("rpt_off%0d", i), rec_t[i] - rec_t[0], exp_off[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
